// File: rtl/cordic_sweep_ctrl.sv
// Angle sweep sequencer for a free-running cordic core.
// Issues an angle, waits for the pipeline, captures sin/cos, dwells, steps.
module cordic_sweep_ctrl #(
   parameter int FPSHIFT = 8,
   parameter int LATENCY = 16,
   parameter int DWELL   = 2097152,
   parameter int STEP    = 256,
   parameter int START   = 69632
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   input  logic signed [31:0] cos_in,
   input  logic signed [31:0] sin_in,
   output logic signed [31:0] angle_out,
   output logic signed [31:0] cos_out,
   output logic signed [31:0] sin_out,
   output logic               result_valid,
   output logic               busy,
   output logic [15:0]        sample_count
);

   localparam int          FULL_I = 360 << FPSHIFT;
   localparam logic [32:0] FULL   = 33'(FULL_I);
   localparam logic [32:0] STEP33 = 33'(STEP);
   localparam logic [31:0] LAT    = 32'(LATENCY);
   localparam logic [31:0] DWL    = 32'(DWELL);
   localparam logic [31:0] ST     = 32'(START);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_DWELL
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        oneshot_q, oneshot_d;
   logic [31:0] angle_q, angle_d;
   logic [31:0] cos_q, cos_d;
   logic [31:0] sin_q, sin_d;
   logic [15:0] count_q, count_d;
   logic        valid_q, valid_d;
   logic [32:0] sum;
   logic [31:0] angle_nx;
   logic        cnt_last;

   assign cnt_last = (cnt_q <= 32'd1);

   // Wrap back into [0, 360 deg) using a carry-safe 33-bit sum
   always_comb begin
      sum      = {1'b0, angle_q} + STEP33;
      angle_nx = sum[31:0];
      if (sum >= FULL) begin
         angle_nx = 32'(sum - FULL);
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (run || step) begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_last) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            state_d = S_DWELL;
         end
         S_DWELL: begin
            if (cnt_last) begin
               state_d = (run && !oneshot_q) ? S_SETTLE : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   always_comb begin
      cnt_d     = cnt_q;
      oneshot_d = oneshot_q;
      angle_d   = angle_q;
      cos_d     = cos_q;
      sin_d     = sin_q;
      count_d   = count_q;
      valid_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               cnt_d = LAT;
            end else if (step) begin
               cnt_d     = LAT;
               oneshot_d = 1'b1;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - 32'd1;
         end
         S_CAPTURE: begin
            cos_d   = cos_in;
            sin_d   = sin_in;
            count_d = count_q + 16'd1;
            valid_d = 1'b1;
            cnt_d   = DWL;
         end
         S_DWELL: begin
            if (cnt_last) begin
               angle_d   = angle_nx;
               oneshot_d = 1'b0;
               cnt_d     = LAT;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: begin
            cnt_d = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 32'd0;
         oneshot_q <= 1'b0;
         angle_q   <= ST;
         cos_q     <= 32'd0;
         sin_q     <= 32'd0;
         count_q   <= 16'd0;
         valid_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         oneshot_q <= oneshot_d;
         angle_q   <= angle_d;
         cos_q     <= cos_d;
         sin_q     <= sin_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
      end
   end

   assign angle_out    = angle_q;
   assign cos_out      = cos_q;
   assign sin_out      = sin_q;
   assign result_valid = valid_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Directed bench for cordic_sweep_ctrl: cycle table plus corner sequences.
module tb_cordic_sweep_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic stp = 1'b0;
   logic run_b = 1'b0;
   logic stp_b = 1'b0;
   logic signed [31:0] cos_in = '0;
   logic signed [31:0] sin_in = '0;
   logic signed [31:0] angle_o, cos_o, sin_o;
   logic signed [31:0] angle_b, cos_b, sin_b;
   logic valid_o, busy_o, valid_b, busy_b;
   logic [15:0] cnt_o, cnt_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   cordic_sweep_ctrl #(
      .FPSHIFT(8), .LATENCY(4), .DWELL(3),
      .STEP(23040), .START(69632)
   ) u_dut (
      .clk(clk), .rst(rst), .run(run), .step(stp),
      .cos_in(cos_in), .sin_in(sin_in),
      .angle_out(angle_o), .cos_out(cos_o), .sin_out(sin_o),
      .result_valid(valid_o), .busy(busy_o),
      .sample_count(cnt_o)
   );

   cordic_sweep_ctrl #(
      .FPSHIFT(8), .LATENCY(1), .DWELL(1),
      .STEP(256), .START(91904)
   ) u_b (
      .clk(clk), .rst(rst), .run(run_b), .step(stp_b),
      .cos_in(cos_in), .sin_in(sin_in),
      .angle_out(angle_b), .cos_out(cos_b), .sin_out(sin_b),
      .result_valid(valid_b), .busy(busy_b),
      .sample_count(cnt_b)
   );

   typedef struct {
      logic [31:0] ci;
      logic [31:0] si;
      logic        ev;
      logic        eb;
      logic [31:0] ea;
      logic [31:0] eco;
      logic [31:0] esi;
      logic [15:0] ecnt;
   } vec_t;

   localparam logic [31:0] A0 = 32'd69632;
   localparam logic [31:0] A1 = 32'd512;
   localparam logic [31:0] A2 = 32'd23552;
   localparam logic [31:0] A3 = 32'd46592;
   localparam logic [31:0] CG = 32'hDEAD_0000;
   localparam logic [31:0] SG = 32'hBEEF_0000;
   localparam logic [31:0] C1 = 32'hFFFF_F000;
   localparam logic [31:0] S1 = 32'h0000_1234;
   localparam logic [31:0] C2 = 32'h0000_0100;
   localparam logic [31:0] S2 = 32'h0000_0200;
   localparam logic [31:0] C3 = 32'h8000_0000;
   localparam logic [31:0] S3 = 32'h7FFF_FFFF;
   localparam logic [31:0] C4 = 32'h0000_0001;
   localparam logic [31:0] S4 = 32'hFFFF_FFFF;

   vec_t v [34];

   function automatic vec_t mk(
      logic [31:0] ci, logic [31:0] si,
      logic ev, logic eb, logic [31:0] ea,
      logic [31:0] eco, logic [31:0] esi,
      logic [15:0] ecnt);
      vec_t r;
      r.ci = ci; r.si = si; r.ev = ev; r.eb = eb;
      r.ea = ea; r.eco = eco; r.esi = esi;
      r.ecnt = ecnt;
      return r;
   endfunction

   task automatic chk(string nm, int cyc,
                      logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc %0d: got %h want %h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0; stp = 1'b0; run_b = 1'b0;
      cos_in = CG; sin_in = SG;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int np, first, last;

      v[0] = mk(CG, SG, 0, 0, A0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) v[i] = mk(CG, SG, 0, 1, A0, 0, 0, 0);
      v[5] = mk(C1, S1, 0, 1, A0, 0, 0, 0);
      v[6] = mk(CG, SG, 1, 1, A0, C1, S1, 1);
      for (int i = 7; i <= 8; i++) v[i] = mk(CG, SG, 0, 1, A0, C1, S1, 1);
      for (int i = 9; i <= 12; i++) v[i] = mk(CG, SG, 0, 1, A1, C1, S1, 1);
      v[13] = mk(C2, S2, 0, 1, A1, C1, S1, 1);
      v[14] = mk(CG, SG, 1, 1, A1, C2, S2, 2);
      for (int i = 15; i <= 16; i++) v[i] = mk(CG, SG, 0, 1, A1, C2, S2, 2);
      for (int i = 17; i <= 20; i++) v[i] = mk(CG, SG, 0, 1, A2, C2, S2, 2);
      v[21] = mk(C3, S3, 0, 1, A2, C2, S2, 2);
      v[22] = mk(CG, SG, 1, 1, A2, C3, S3, 3);
      for (int i = 23; i <= 24; i++) v[i] = mk(CG, SG, 0, 1, A2, C3, S3, 3);
      for (int i = 25; i <= 28; i++) v[i] = mk(CG, SG, 0, 1, A3, C3, S3, 3);
      v[29] = mk(C4, S4, 0, 1, A3, C3, S3, 3);
      v[30] = mk(CG, SG, 1, 1, A3, C4, S4, 4);
      for (int i = 31; i <= 32; i++) v[i] = mk(CG, SG, 0, 1, A3, C4, S4, 4);
      v[33] = mk(CG, SG, 0, 1, A0, C4, S4, 4);

      // continuous sweep with capture-only input values
      do_reset();
      for (int i = 0; i < 34; i++) begin
         run = 1'b1;
         cos_in = v[i].ci;
         sin_in = v[i].si;
         chk("valid", i, 32'(valid_o), 32'(v[i].ev));
         chk("busy", i, 32'(busy_o), 32'(v[i].eb));
         chk("angle", i, angle_o, v[i].ea);
         chk("cos", i, cos_o, v[i].eco);
         chk("sin", i, sin_o, v[i].esi);
         chk("count", i, 32'(cnt_o), 32'(v[i].ecnt));
         tick();
      end

      // single step, with a second step while busy
      do_reset();
      np = 0; first = -1;
      for (int c = 0; c <= 20; c++) begin
         stp = (c == 0 || c == 3);
         if (valid_o) begin
            np++;
            if (first < 0) first = c;
         end
         if (c == 9) begin
            chk("step_busy", c, 32'(busy_o), 32'd0);
            chk("step_angle", c, angle_o, A1);
         end
         tick();
      end
      stp = 1'b0;
      chk("step_pulses", 20, np, 1);
      chk("step_first", 20, first, 6);
      chk("step_count", 20, 32'(cnt_o), 32'd1);

      // run and step together: run wins, sweep continues
      do_reset();
      np = 0;
      for (int c = 0; c <= 15; c++) begin
         run = 1'b1;
         stp = (c == 0);
         if (valid_o) np++;
         tick();
      end
      chk("runstep_pulses", 15, np, 2);

      // run dropped during settle of sample 2
      do_reset();
      np = 0; last = -1;
      for (int c = 0; c <= 40; c++) begin
         run = (c < 10);
         if (valid_o) begin
            np++;
            last = c;
         end
         if (c == 17) begin
            chk("pause_busy", c, 32'(busy_o), 32'd0);
            chk("pause_angle", c, angle_o, A2);
         end
         tick();
      end
      chk("pause_pulses", 40, np, 2);
      chk("pause_last", 40, last, 14);
      chk("pause_idle", 40, 32'(busy_o), 32'd0);

      // asynchronous reset mid-dwell
      do_reset();
      run = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      chk("pre_rst_valid", 6, 32'(valid_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_angle", 6, angle_o, A0);
      chk("arst_count", 6, 32'(cnt_o), 32'd0);
      chk("arst_valid", 6, 32'(valid_o), 32'd0);
      chk("arst_busy", 6, 32'(busy_o), 32'd0);
      chk("arst_sin", 6, sin_o, 32'd0);
      chk("arst_cos", 6, cos_o, 32'd0);

      // wrap at 360 deg, minimum latency and dwell
      do_reset();
      np = 0;
      for (int c = 0; c <= 7; c++) begin
         run_b = 1'b1;
         if (valid_b) np++;
         if (c == 0) chk("b_angle0", c, angle_b, 32'd91904);
         if (c == 3) chk("b_valid3", c, 32'(valid_b), 32'd1);
         if (c == 4) begin
            chk("b_valid4", c, 32'(valid_b), 32'd0);
            chk("b_wrap", c, angle_b, 32'd0);
         end
         if (c == 6) chk("b_valid6", c, 32'(valid_b), 32'd1);
         if (c == 7) chk("b_angle7", c, angle_b, 32'd256);
         tick();
      end
      chk("b_pulses", 7, np, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
